adder_sched: RTL and testbench

Round-robin scheduler that shares the single 16-bit `adder` datapath between NREQ requesters, such as the ALU, PC incrementer and IX/IY displacement unit. It sequences each operation, including a second adder pass for carry-in operations (ADC/SBC), registers the result and flags, and returns them with a one-hot done pulse. It sits between the instruction decoder's operand muxes and the shared `adder` instance.

---
 rtl/adder_sched_pkg.sv | 39 +++
 rtl/adder.sv | 43 ++++
 rtl/rr_pick.sv | 28 ++
 rtl/adder_sched.sv | 100 ++++++++++
 tb/tb_adder_sched.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/adder_sched_pkg.sv
// Shared types and flag layout for the adder scheduler and its datapath.
package adder_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int FLG_C  = 0;
  localparam int FLG_N  = 1;
  localparam int FLG_PV = 2;
  localparam int FLG_F3 = 3;
  localparam int FLG_H  = 4;
  localparam int FLG_F5 = 5;
  localparam int FLG_Z  = 6;
  localparam int FLG_S  = 7;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        opp;
    logic        size;
    logic        use_c;
    logic        cin;
  } op_t;

  // Carry ops: result-shaped flags come from pass 2; carries accumulate and overflow cancels.
  function automatic logic [7:0] merge_carry_flags(input logic [7:0] f1, input logic [7:0] f2);
    logic [7:0] f;
    f         = f2;
    f[FLG_C]  = f1[FLG_C] | f2[FLG_C];
    f[FLG_H]  = f1[FLG_H] | f2[FLG_H];
    f[FLG_PV] = f1[FLG_PV] ^ f2[FLG_PV];
    return f;
  endfunction

endpackage

// File: rtl/adder.sv
// Shared 8/16-bit add/subtract datapath; subtract is a + ~b + 1, carry/half report borrow.
module adder
  import adder_sched_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        opp,
  input  logic        size,
  output logic [15:0] out,
  output logic [7:0]  flags
);

  logic [15:0] bx;
  logic [8:0]  s9;
  logic [16:0] s17;

  always_comb begin
    bx    = opp ? ~b : b;
    s9    = {1'b0, a[7:0]} + {1'b0, bx[7:0]} + {8'b0, opp};
    s17   = {1'b0, a} + {1'b0, bx} + {16'b0, opp};
    flags = '0;
    if (size) begin
      out           = s17[15:0];
      flags[FLG_S]  = s17[15];
      flags[FLG_F5] = s17[13];
      flags[FLG_F3] = s17[11];
      flags[FLG_H]  = a[12] ^ bx[12] ^ s17[12] ^ opp;
      flags[FLG_PV] = (a[15] == bx[15]) && (s17[15] != a[15]);
      flags[FLG_C]  = s17[16] ^ opp;
    end else begin
      out           = {8'h00, s9[7:0]};
      flags[FLG_S]  = s9[7];
      flags[FLG_F5] = s9[5];
      flags[FLG_F3] = s9[3];
      flags[FLG_H]  = a[4] ^ bx[4] ^ s9[4] ^ opp;
      flags[FLG_PV] = (a[7] == bx[7]) && (s9[7] != a[7]);
      flags[FLG_C]  = s9[8] ^ opp;
    end
    flags[FLG_Z] = (out == 16'h0000);
    flags[FLG_N] = opp;
  end

endmodule

// File: rtl/rr_pick.sv
// Circular first-set search starting just after the last served lane.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (int'(last) + k) % NREQ;
      if (!any && req[j]) begin
        any     = 1'b1;
        pick[j] = 1'b1;
        idx     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/adder_sched.sv
// Round-robin owner of the shared adder; carry ops take a second pass adding cin to pass-1 output.
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   a_in,
  input  logic [16*NREQ-1:0]   b_in,
  input  logic [NREQ-1:0]      opp_in,
  input  logic [NREQ-1:0]      size_in,
  input  logic [NREQ-1:0]      use_c_in,
  input  logic [NREQ-1:0]      cin_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [15:0]          result,
  output logic [7:0]           flags,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  op_t             op;
  logic [IW-1:0]   last;
  logic [7:0]      flg1;
  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [15:0]     sum;
  logic [7:0]      sum_flg;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  adder u_adder (
    .a     (op.a),
    .b     (op.b),
    .opp   (op.opp),
    .size  (op.size),
    .out   (sum),
    .flags (sum_flg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      op     <= '0;
      last   <= IW'(NREQ - 1);
      flg1   <= '0;
      gnt    <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pick_any) begin
          op    <= '{a:     a_in[16*pick_idx +: 16],
                     b:     b_in[16*pick_idx +: 16],
                     opp:   opp_in[pick_idx],
                     size:  size_in[pick_idx],
                     use_c: use_c_in[pick_idx],
                     cin:   cin_in[pick_idx]};
          last  <= pick_idx;
          gnt   <= pick;
          state <= ST_PASS1;
        end
        ST_PASS1: if (op.use_c) begin
          op.a  <= sum;
          op.b  <= {15'b0, op.cin};
          flg1  <= sum_flg;
          state <= ST_PASS2;
        end else begin
          result <= sum;
          flags  <= sum_flg;
          state  <= ST_RESP;
        end
        ST_PASS2: begin
          result <= sum;
          flags  <= merge_carry_flags(flg1, sum_flg);
          state  <= ST_RESP;
        end
        default: begin
          gnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign done = (state == ST_RESP) ? gnt : '0;
  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_adder_sched.sv
// Directed checks of adder_sched: latency, arithmetic/flags, rotation, mid-op reset and req drop.
module tb_adder_sched;

  localparam int NREQ = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [16*NREQ-1:0]  a_in, b_in;
  logic [NREQ-1:0]     opp_in, size_in, use_c_in, cin_in;
  logic [NREQ-1:0]     gnt, done;
  logic [15:0]         result;
  logic [7:0]          flags;
  logic                busy;

  int nchk = 0;
  int nerr = 0;

  adder_sched #(.NREQ(NREQ)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .a_in     (a_in),
    .b_in     (b_in),
    .opp_in   (opp_in),
    .size_in  (size_in),
    .use_c_in (use_c_in),
    .cin_in   (cin_in),
    .gnt      (gnt),
    .done     (done),
    .result   (result),
    .flags    (flags),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [15:0] a, input logic [15:0] b,
                          input logic opp, input logic size, input logic use_c, input logic cin);
    a_in[16*l +: 16] = a;
    b_in[16*l +: 16] = b;
    opp_in[l]   = opp;
    size_in[l]  = size;
    use_c_in[l] = use_c;
    cin_in[l]   = cin;
  endtask

  // Raise req for one lane and wait (bounded) for its done; optionally drop req in PASS1.
  task automatic run_op(input string tag, input int l, input bit drop, input int exp_lat,
                        input logic [15:0] exp_res, input logic [7:0] exp_flg);
    logic [NREQ-1:0] oh;
    int n;
    oh = '0;
    oh[l] = 1'b1;
    req[l] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
        if (drop) req[l] = 1'b0;
      end
    end while (done == '0 && n < 10);
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_done"}, 32'(done), 32'(oh));
    chk({tag, "_res"}, 32'(result), 32'(exp_res));
    chk({tag, "_flg"}, 32'(flags), 32'(exp_flg));
    req[l] = 1'b0;
  endtask

  logic [NREQ-1:0] order [$];
  int              ndone;

  initial begin
    reset = 1'b1;
    req = '0; a_in = '0; b_in = '0;
    opp_in = '0; size_in = '0; use_c_in = '0; cin_in = '0;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res", 32'(result), 0);
    chk("rst_flg", 32'(flags), 0);
    reset = 1'b0;

    set_lane(0, 16'h0012, 16'h0034, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add8", 0, 1'b0, 2, 16'h0046, 8'h00);
    tick();
    chk("idle_busy", 32'(busy), 0);

    set_lane(1, 16'h007F, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op("adc8", 1, 1'b0, 3, 16'h0080, 8'h94);
    tick();

    set_lane(2, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
    run_op("sbc16", 2, 1'b0, 3, 16'hFFFF, 8'hBB);
    tick();

    set_lane(2, 16'h1000, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("sub16", 2, 1'b0, 2, 16'h0FFF, 8'h1A);
    tick();

    // Continuous requests on all lanes: plain ops, so four grants fit in 12 cycles.
    set_lane(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    set_lane(1, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    set_lane(2, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
    req = '1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done != '0) begin
        ndone++;
        chk("rr_onehot", 32'($countones(done)), 1);
        chk("rr_done_gnt", 32'(done), 32'(gnt));
        order.push_back(done);
      end
    end
    req = '0;
    chk("rr_count", ndone, 4);
    if (order.size() >= 4) begin
      chk("rr_ord0", 32'(order[0]), 32'h1);
      chk("rr_ord1", 32'(order[1]), 32'h2);
      chk("rr_ord2", 32'(order[2]), 32'h4);
      chk("rr_ord3", 32'(order[3]), 32'h1);
    end
    tick(); tick();

    // Reset during PASS2 of a carry op.
    set_lane(1, 16'h00F0, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b1);
    req[1] = 1'b1;
    tick();
    chk("rmid_gnt_pre", 32'(gnt), 32'h2);
    tick();
    chk("rmid_busy_pre", 32'(busy), 1);
    reset = 1'b1;
    req = '0;
    tick();
    chk("rmid_gnt", 32'(gnt), 0);
    chk("rmid_done", 32'(done), 0);
    chk("rmid_busy", 32'(busy), 0);
    chk("rmid_res", 32'(result), 0);
    chk("rmid_flg", 32'(flags), 0);
    reset = 1'b0;
    tick();
    chk("rmid_nodone", 32'(done), 0);

    // Lane 0 drops req in PASS1; op still completes.
    set_lane(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("drop", 0, 1'b1, 2, 16'h0000, 8'h51);
    tick();
    tick();
    chk("drop_idle_busy", 32'(busy), 0);
    chk("drop_idle_gnt", 32'(gnt), 0);
    chk("drop_idle_done", 32'(done), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
